// File: rtl/dec_op_seq_if.sv
// dec_op_seq_if: operand/opcode request and result bundle for dec_op_seq
interface dec_op_seq_if #(parameter int W = 4);
  logic           enable;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [1:0]     dec;
  logic           busy;
  logic           done;
  logic [3:0]     sel;
  logic [2*W-1:0] c;
  modport master(output enable, start, a, b, dec, input busy, done, sel, c);
  modport slave(input enable, start, a, b, dec, output busy, done, sel, c);
endinterface

// File: rtl/dec_op_seq.sv
// dec_op_seq: handshaked add/sub/shift-add multiply/xor unit with one-hot op tag
module dec_op_seq #(
  parameter int W = 4
) (
  input  logic        clk,
  input  logic        rst,
  dec_op_seq_if.slave bus
);
  localparam int CW = $clog2(W);
  typedef enum logic {IDLE, RUN} state_t;
  state_t         state, state_n;
  logic [2*W-1:0] mc, acc, prod, res, c;
  logic [W-1:0]   mb;
  logic [1:0]     op;
  logic [3:0]     sel;
  logic [CW-1:0]  cnt;
  logic           done, accept, step, fin;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    accept  = state == IDLE && bus.enable && bus.start;
    step    = state == RUN && bus.enable;
    fin     = step && (op != 2'd2 || cnt == '0);
    state_n = accept ? RUN : fin ? IDLE : state;
  end
  // mc doubles as the zero-extended operand X and the left-shifting multiplicand
  always_comb begin
    prod = acc + (mb[0] ? mc : '0);
    res  = op == 2'd0 ? mc + {{W{1'b0}}, mb} :
           op == 2'd1 ? mc - {{W{1'b0}}, mb} :
           op == 2'd3 ? mc ^ {{W{1'b0}}, mb} : prod;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mc   <= '0;
      mb   <= '0;
      op   <= '0;
      sel  <= '0;
      acc  <= '0;
      cnt  <= '0;
      c    <= '0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (accept) begin
        mc  <= {{W{1'b0}}, bus.a};
        mb  <= bus.b;
        op  <= bus.dec;
        sel <= 4'b0001 << bus.dec;
        acc <= '0;
        cnt <= CW'(W - 1);
      end else if (step && op == 2'd2) begin
        acc <= prod;
        mc  <= mc << 1;
        mb  <= mb >> 1;
        cnt <= cnt - 1'b1;
      end
      if (fin) c <= res;
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = done;
  assign bus.sel  = sel;
  assign bus.c    = c;
endmodule
